// File: rtl/count_monitor_if.sv
// Handshake bundle between the counter monitor and its host.
// The host drives the sampling inputs; the monitor returns flags and statistics.
interface count_monitor_if #(
    parameter int WRAP_W = 16
);
    logic              en;
    logic [7:0]        count;
    logic              clr;
    logic              irq_ack;
    logic              irq;
    logic              stall;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [7:0]        max_seen;
    logic [1:0]        state;

    modport master (
        output en, count, clr, irq_ack,
        input  irq, stall, wrap_cnt, max_seen, state
    );

    modport slave (
        input  en, count, clr, irq_ack,
        output irq, stall, wrap_cnt, max_seen, state
    );
endinterface

// File: rtl/count_monitor.sv
// Watches an upstream 8-bit counter for wraps, stalls, peak value and
// threshold crossings; every output comes straight from a flop.
module count_monitor #(
    parameter logic [7:0]  THRESH    = 8'd200,
    parameter int unsigned STALL_LIM = 4,
    parameter int          WRAP_W    = 16
) (
    input logic           clk,
    input logic           rst,
    count_monitor_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] ALERT = 2'd2;
    localparam logic [1:0] REARM = 2'd3;
    localparam logic [3:0] LIM   = STALL_LIM[3:0];

    logic [7:0]        count_q, count_d;
    logic              prev_valid_q, prev_valid_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [7:0]        max_seen_q, max_seen_d;
    logic [3:0]        run_q, run_d;
    logic              stall_q, stall_d;
    logic [1:0]        state_q, state_d;
    logic              irq_q, irq_d;
    logic              wrap;
    logic              same;
    logic              hit;

    assign wrap = prev_valid_q && bus.en && (bus.count < count_q);
    assign same = prev_valid_q && bus.en && (bus.count == count_q);
    assign hit  = bus.en && (bus.count >= THRESH);

    always_comb begin
        count_d      = bus.en ? bus.count : count_q;
        prev_valid_d = bus.en;
        wrap_cnt_d   = wrap_cnt_q;
        max_seen_d   = max_seen_q;
        run_d        = 4'd0;
        stall_d      = stall_q || (run_q >= LIM);
        state_d      = state_q;

        if (wrap && (wrap_cnt_q != {WRAP_W{1'b1}}))
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        if (bus.en && (bus.count > max_seen_q))
            max_seen_d = bus.count;
        if (same)
            run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;

        case (state_q)
            IDLE:  if (bus.en) state_d = RUN;
            RUN: begin
                if (hit)          state_d = ALERT;
                else if (!bus.en) state_d = IDLE;
            end
            ALERT: if (bus.irq_ack) state_d = REARM;
            REARM: begin
                // No re-alert until the count has fallen below threshold
                if (bus.en && (bus.count < THRESH)) state_d = RUN;
                else if (!bus.en)                   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.clr) begin
            prev_valid_d = 1'b0;
            wrap_cnt_d   = '0;
            max_seen_d   = 8'd0;
            run_d        = 4'd0;
            stall_d      = 1'b0;
            state_d      = IDLE;
        end

        irq_d = (state_d == ALERT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= 8'd0;
            prev_valid_q <= 1'b0;
            wrap_cnt_q   <= '0;
            max_seen_q   <= 8'd0;
            run_q        <= 4'd0;
            stall_q      <= 1'b0;
            state_q      <= IDLE;
            irq_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            prev_valid_q <= prev_valid_d;
            wrap_cnt_q   <= wrap_cnt_d;
            max_seen_q   <= max_seen_d;
            run_q        <= run_d;
            stall_q      <= stall_d;
            state_q      <= state_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.irq      = irq_q;
    assign bus.stall    = stall_q;
    assign bus.wrap_cnt = wrap_cnt_q;
    assign bus.max_seen = max_seen_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a vector table plus short sequences
// for threshold re-arm, stall, saturation, clear and reset corners.
module tb_count_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    count_monitor_if #(.WRAP_W(16)) bus1 ();
    count_monitor_if #(.WRAP_W(2))  bus2 ();

    count_monitor #(.THRESH(8'd200), .STALL_LIM(4), .WRAP_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    count_monitor #(.THRESH(8'd200), .STALL_LIM(4), .WRAP_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct {
        logic       en;
        logic [7:0] cnt;
        logic       clr;
        logic       ack;
        int         st;
        int         irq;
        int         stall;
        int         wrap;
        int         mx;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [7:0] c,
                         input logic cl, input logic a);
        bus1.en      = e;
        bus1.count   = c;
        bus1.clr     = cl;
        bus1.irq_ack = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int st, input int irq,
                           input int stl, input int wr, input int mx);
        chk({tag, ".state"},    int'(bus1.state),    st);
        chk({tag, ".irq"},      int'(bus1.irq),      irq);
        chk({tag, ".stall"},    int'(bus1.stall),    stl);
        chk({tag, ".wrap_cnt"}, int'(bus1.wrap_cnt), wr);
        chk({tag, ".max_seen"}, int'(bus1.max_seen), mx);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'd10,  1'b0, 1'b0, 1, 0, 0, 0, 10};
        tbl[1]  = '{1'b1, 8'd20,  1'b0, 1'b0, 1, 0, 0, 0, 20};
        tbl[2]  = '{1'b1, 8'd5,   1'b0, 1'b0, 1, 0, 0, 1, 20};
        tbl[3]  = '{1'b0, 8'd7,   1'b0, 1'b0, 0, 0, 0, 1, 20};
        tbl[4]  = '{1'b1, 8'd3,   1'b0, 1'b0, 1, 0, 0, 1, 20};
        tbl[5]  = '{1'b1, 8'd200, 1'b0, 1'b0, 2, 1, 0, 1, 200};
        tbl[6]  = '{1'b0, 8'd0,   1'b0, 1'b0, 2, 1, 0, 1, 200};
        tbl[7]  = '{1'b1, 8'd150, 1'b0, 1'b1, 3, 0, 0, 1, 200};
        tbl[8]  = '{1'b1, 8'd210, 1'b0, 1'b0, 3, 0, 0, 1, 210};
        tbl[9]  = '{1'b1, 8'd100, 1'b0, 1'b0, 1, 0, 0, 2, 210};
        tbl[10] = '{1'b1, 8'd199, 1'b0, 1'b1, 1, 0, 0, 2, 210};
        tbl[11] = '{1'b1, 8'd255, 1'b0, 1'b1, 2, 1, 0, 2, 255};
        tbl[12] = '{1'b1, 8'd255, 1'b0, 1'b0, 2, 1, 0, 2, 255};
        tbl[13] = '{1'b1, 8'd0,   1'b1, 1'b0, 0, 0, 0, 0, 0};

        bus2.en = 1'b0; bus2.count = 8'd0;
        bus2.clr = 1'b0; bus2.irq_ack = 1'b0;

        do_reset();
        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].cnt, tbl[i].clr, tbl[i].ack);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].irq,
                    tbl[i].stall, tbl[i].wrap, tbl[i].mx);
        end

        // Full ramp 0..255 then back to 0
        do_reset();
        for (int c = 0; c < 256; c++) begin
            drive(1'b1, 8'(c), 1'b0, 1'b0);
            step();
            if (c == 199) chk("ramp.irq@199", int'(bus1.irq), 0);
            if (c == 200) chk("ramp.irq@200", int'(bus1.irq), 1);
        end
        drive(1'b1, 8'd0, 1'b0, 1'b0);
        step();
        chk("ramp.wrap_cnt", int'(bus1.wrap_cnt), 1);
        chk("ramp.max_seen", int'(bus1.max_seen), 255);
        chk("ramp.irq_hold", int'(bus1.irq), 1);

        // Acknowledge while still above threshold, then re-arm
        drive(1'b1, 8'd220, 1'b0, 1'b1);
        step();
        chk("ack.state", int'(bus1.state), 3);
        chk("ack.irq",   int'(bus1.irq),   0);
        drive(1'b1, 8'd230, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'd240, 1'b0, 1'b0);
        step();
        chk("rearm.state", int'(bus1.state), 3);
        chk("rearm.irq",   int'(bus1.irq),   0);
        drive(1'b1, 8'd10, 1'b0, 1'b0);
        step();
        chk("rearm.run", int'(bus1.state), 1);
        drive(1'b1, 8'd200, 1'b0, 1'b0);
        step();
        chk("realert.irq",   int'(bus1.irq),   1);
        chk("realert.state", int'(bus1.state), 2);

        // Stall: count held at 42 for five samples
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        step();
        chk("clr.state", int'(bus1.state), 0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'd42, 1'b0, 1'b0);
            step();
        end
        chk("stall.pre", int'(bus1.stall), 0);
        drive(1'b1, 8'd43, 1'b0, 1'b0);
        step();
        chk("stall.set", int'(bus1.stall), 1);
        drive(1'b1, 8'd44, 1'b0, 1'b0);
        step();
        chk("stall.sticky", int'(bus1.stall), 1);
        drive(1'b1, 8'd45, 1'b1, 1'b0);
        step();
        chk("stall.clr", int'(bus1.stall), 0);

        // Clear wins over same-cycle wrap
        drive(1'b1, 8'd100, 1'b0, 1'b0); step();
        drive(1'b1, 8'd50,  1'b0, 1'b0); step();
        drive(1'b1, 8'd255, 1'b0, 1'b0); step();
        chk("clrwrap.pre_wrap", int'(bus1.wrap_cnt), 1);
        chk("clrwrap.pre_irq",  int'(bus1.irq),      1);
        drive(1'b1, 8'd250, 1'b1, 1'b0);
        step();
        chk_all("clrwrap", 0, 0, 0, 0, 0);

        // Reset in ALERT overrides clr
        drive(1'b1, 8'd10,  1'b0, 1'b0); step();
        drive(1'b1, 8'd200, 1'b0, 1'b0); step();
        chk("rstalert.pre_irq", int'(bus1.irq), 1);
        rst = 1'b1;
        drive(1'b1, 8'd50, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        chk_all("rstalert", 0, 0, 0, 0, 0);
        drive(1'b0, 8'd60, 1'b0, 1'b0);
        step();
        step();
        chk("rstalert.idle", int'(bus1.state), 0);
        drive(1'b1, 8'd60, 1'b0, 1'b0);
        step();
        chk("rstalert.run", int'(bus1.state), 1);

        // Saturation with a 2-bit wrap counter
        for (int k = 0; k < 10; k++) begin
            bus2.en    = 1'b1;
            bus2.count = (k % 2 == 0) ? 8'd10 : 8'd5;
            step();
            if (k == 5) chk("sat.wrap3", int'(bus2.wrap_cnt), 3);
        end
        chk("sat.wrap5", int'(bus2.wrap_cnt), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
